// File: rtl/tiny8_types.sv
// tiny8_types: shared types for the tiny8 datapath.
//   tiny8_word      - 8-bit data word
//   tiny8_aluop     - ALU operation code (encoding 2'd3 is unassigned and yields 0)
//   tiny8_arb_state - state of the ALU arbiter FSM
//   TINY8_MAX_REQ   - largest supported number of ALU requesters
package tiny8_types;

  typedef logic [7:0] tiny8_word;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } tiny8_aluop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } tiny8_arb_state;

  localparam int TINY8_MAX_REQ = 4;

endpackage

// File: rtl/alu.sv
// alu: combinational tiny8 ALU, all results mod 256.
//   op - operation (add, sub, mul; any other code gives 0x00)
//   a  - first operand
//   b  - second operand (mul uses only b[3:0])
//   f  - result
module alu
  import tiny8_types::*;
(
  input  tiny8_aluop op,
  input  tiny8_word  a,
  input  tiny8_word  b,
  output tiny8_word  f
);

  always_comb begin
    f = '0;
    case (op)
      ALU_ADD: f = a + b;
      ALU_SUB: f = a - b;
      // Multiplier is a x 4-bit; the upper nibble of b is ignored.
      ALU_MUL: f = a * {4'b0000, b[3:0]};
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one tiny8 alu between NREQ requesters.
// One request is accepted at a time: operands are registered (IDLE), the alu
// result is registered (EXEC), and the result is held for the owner (RESP)
// until that owner accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is one-hot or zero and only asserted in IDLE;
// resp_valid is one-hot or zero and only asserted to the owner in RESP.
// Requesters hold req_valid and payload stable until accepted.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester request handshake
//   req_op/req_a/req_b  - per-requester payload
//   resp_valid          - per-requester response valid
//   resp_data           - shared result bus (keeps last result)
//   resp_ready          - per-requester response accept
//   dbg_state           - current FSM state
//
// Build option: TINY8_ALU_ARB_RR_EN selects round-robin arbitration; when it
// is undefined, fixed priority (lowest index wins) is used.
module alu_arbiter
  import tiny8_types::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  tiny8_aluop           req_op [NREQ],
  input  tiny8_word            req_a  [NREQ],
  input  tiny8_word            req_b  [NREQ],
  output logic [NREQ-1:0]      resp_valid,
  output tiny8_word            resp_data,
  input  logic [NREQ-1:0]      resp_ready,
  output tiny8_arb_state       dbg_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDXW-1:0] idx_t;

  tiny8_arb_state  state;
  idx_t            owner;
  idx_t            win;
  logic [NREQ-1:0] grant;
  tiny8_aluop      op_q;
  tiny8_word       a_q;
  tiny8_word       b_q;
  tiny8_word       result;
  tiny8_word       alu_f;

`ifdef TINY8_ALU_ARB_RR_EN
  idx_t rr_ptr;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx_t'(idx);
      end
    end
  end
`else
  // Scan from the top down so the lowest valid index is the last writer.
  always_comb begin
    grant = '0;
    win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        win      = idx_t'(k);
      end
    end
  end
`endif

  // Gated by rst_n so no grant is visible while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      op_q   <= ALU_ADD;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
`ifdef TINY8_ALU_ARB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= win;
            op_q  <= req_op[win];
            a_q   <= req_a[win];
            b_q   <= req_b[win];
            state <= EXEC;
`ifdef TINY8_ALU_ARB_RR_EN
            rr_ptr <= (int'(win) == NREQ - 1) ? '0 : idx_t'(win + 1'b1);
`endif
          end
        end
        EXEC: begin
          result <= alu_f;
          state  <= RESP;
        end
        RESP: begin
          // Only the owner's accept ends the response.
          if (resp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[owner] = 1'b1;
  end

  assign resp_data = result;
  assign dbg_state = state;

  alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .f  (alu_f)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (NREQ = 2) with a
// transaction-level reference model checked on every falling clock edge.
// Honours TINY8_ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;
  import tiny8_types::*;

  localparam int NREQ = 2;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  tiny8_aluop     req_op [NREQ];
  tiny8_word      req_a  [NREQ];
  tiny8_word      req_b  [NREQ];
  logic [1:0]     resp_valid;
  tiny8_word      resp_data;
  logic [1:0]     resp_ready;
  tiny8_arb_state dbg_state;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] alu_ref(input int op, input int a, input int b);
    case (op)
      0:       return 8'((a + b) % 256);
      1:       return 8'((a - b + 256) % 256);
      2:       return 8'((a * (b % 16)) % 256);
      default: return 8'h00;
    endcase
  endfunction

  function automatic int pick(input logic [1:0] v, input int ptr);
    int start;
`ifdef TINY8_ALU_ARB_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  logic [7:0] exp_q[$];     // result owed to the current owner
  bit         m_busy;       // an operation is in flight
  bit         m_shown;      // its result is on the response bus
  int         m_owner;
  int         m_ptr;
  int         m_w;
  logic [7:0] m_data;       // value the result bus must carry
  int         grant_q[$];   // observed accept order

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_shown = 0; m_owner = 0; m_ptr = 0; m_data = 8'h00;
      exp_q.delete();
    end else if (!m_busy) begin
      m_w = pick(req_valid, m_ptr);
      if (m_w >= 0) begin
        m_busy  = 1;
        m_shown = 0;
        m_owner = m_w;
        exp_q.push_back(alu_ref(int'(req_op[m_w]), int'(req_a[m_w]), int'(req_b[m_w])));
        m_ptr   = (m_w + 1) % NREQ;
      end
    end else if (!m_shown) begin
      m_shown = 1;
      m_data  = exp_q[0];
    end else if (resp_ready[m_owner]) begin
      m_busy = 0;
      void'(exp_q.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [1:0] e_ready;
    logic [1:0] e_valid;
    int         w;
    e_ready = 2'b00;
    e_valid = 2'b00;
    if (rst_n && !m_busy) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) e_ready[w] = 1'b1;
    end
    if (rst_n && m_busy && m_shown) e_valid[m_owner] = 1'b1;
    chk("cyc_req_ready", req_ready, e_ready);
    chk("cyc_resp_valid", resp_valid, e_valid);
    chk("cyc_resp_data", resp_data, m_data);
    if ((req_valid & req_ready) != 2'b00) grant_q.push_back(req_ready[1] ? 1 : 0);
  end

  // ---------------- driver ----------------
  // Issues one request, checks the accept and the T+2 response timing.
  task automatic run_op(input int i, input tiny8_aluop op, input tiny8_word a,
                        input tiny8_word b, input tiny8_word exp, input string name);
    int n;
    @(posedge clk); #1;
    req_op[i] = op; req_a[i] = a; req_b[i] = b; req_valid[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, req_ready[i], 1);
    if (!req_ready[i]) begin
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1 req_valid[i] = 1'b0;
    @(negedge clk);
    chk({name, "_t1_valid"}, resp_valid, 0);
    @(negedge clk);
    chk({name, "_t2_valid"}, resp_valid, 2'b01 << i);
    chk({name, "_data"}, resp_data, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  int exp_grants[4];
  int n;

  initial begin
`ifdef TINY8_ALU_ARB_RR_EN
    exp_grants = '{0, 1, 0, 1};
`else
    exp_grants = '{0, 0, 0, 0};
`endif
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    for (int k = 0; k < NREQ; k++) begin
      req_op[k] = ALU_ADD; req_a[k] = 8'h00; req_b[k] = 8'h00;
    end
    rst_n = 1'b0;
    #2;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_data", resp_data, 8'h00);
    chk("reset_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single request, wrap, multiply, unknown op
    run_op(0, ALU_ADD, 8'h7F, 8'h01, 8'h80, "add");
    run_op(0, ALU_SUB, 8'h00, 8'h01, 8'hFF, "sub_wrap");
    run_op(0, ALU_MUL, 8'h13, 8'hF5, 8'h5F, "mul");
    run_op(1, tiny8_aluop'(2'd3), 8'h12, 8'h34, 8'h00, "unknown_op");

    // Contention: both held valid for four operations
    @(posedge clk); #1;
    grant_q.delete();
    req_op[0] = ALU_ADD; req_a[0] = 8'h01; req_b[0] = 8'h02;
    req_op[1] = ALU_SUB; req_a[1] = 8'h09; req_b[1] = 8'h03;
    req_valid = 2'b11;
    n = 0;
    while (grant_q.size() < 4 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk("contention_count", grant_q.size(), 4);
    @(posedge clk); #1 req_valid = 2'b00;
    for (int k = 0; k < 4; k++)
      if (k < grant_q.size())
        chk($sformatf("contention_grant%0d", k), grant_q[k], exp_grants[k]);
    repeat (4) @(negedge clk);

    // Backpressure on req1, with req0 waiting and a wrong-owner accept
    @(posedge clk); #1 resp_ready = 2'b01;
    run_op(1, ALU_ADD, 8'h10, 8'h20, 8'h30, "bp_req1");
    @(posedge clk); #1;
    req_op[0] = ALU_ADD; req_a[0] = 8'hF0; req_b[0] = 8'h20; req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 2'b10);
      chk("bp_resp_data", resp_data, 8'h30);
      chk("bp_req_ready", req_ready, 0);
      chk("wrong_owner_state", dbg_state, RESP);
    end
    @(posedge clk); #1 resp_ready = 2'b11;
    run_op(0, ALU_ADD, 8'hF0, 8'h20, 8'h10, "bp_req0");

    // Reset while in EXEC
    @(posedge clk); #1;
    req_op[0] = ALU_MUL; req_a[0] = 8'h03; req_b[0] = 8'h03; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst_accept", req_ready[0], 1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    chk("rst_in_exec", dbg_state, EXEC);
    chk("rst_pre_data", resp_data, 8'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_req_ready", req_ready, 0);
    chk("rst_async_resp_valid", resp_valid, 0);
    chk("rst_async_resp_data", resp_data, 8'h00);
    chk("rst_async_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
    end
    run_op(1, ALU_SUB, 8'h05, 8'h07, 8'hFE, "post_rst");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational tiny8 ALU between `NREQ` requesters (decode/execute path, address-generation path, etc.) with a valid/ready handshake on each side. It accepts one request at a time, registers the operands, runs one ALU evaluation and holds the registered result for the granted requester until that requester accepts it. It sits between the core's operation sources and the one shared `alu` instance.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input [NREQ]: per-requester request valid.
- `req_ready` output [NREQ]: per-requester grant. One-hot or zero.
- `req_op` input [NREQ] x `tiny8_aluop`: per-requester operation.
- `req_a`, `req_b` input [NREQ] x `tiny8_word`: per-requester operands.
- `resp_valid` output [NREQ]: result valid, one-hot or zero, only to the granted requester.
- `resp_data` output `tiny8_word`: shared result bus.
- `resp_ready` input [NREQ]: per-requester result accept.
- One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among the asserted `req_valid` bits and drive `req_ready` for the winner only. `req_ready` is combinational from `req_valid` and state.
  - When the handshake `req_valid[i] & req_ready[i]` occurs: latch `req_op[i]`, `req_a[i]`, `req_b[i]` and the owner index `i`, then go to EXEC.
- **EXEC**
  - The ALU evaluates the latched op and operands. The result register loads ALU `f`; go to RESP.
  - `req_ready` is all zero.
- **RESP**
  - `resp_valid[owner]` is 1 and `resp_data` is the result register.
  - On `resp_ready[owner]`, go to IDLE. `resp_ready` of any other requester is ignored.
- **Arithmetic** (all results mod 256, identical to the shared ALU):
  - add: a+b.
  - sub: a−b, with 8-bit wrap.
  - mul: a×b[3:0] truncated to 8 bits; b[7:4] are ignored.
  - An unknown op yields 0x00.
- **Requester rules**
  - A requester must hold `req_valid` and its payload stable until `req_ready`.
  - `req_valid` must not depend on `req_ready`.
  - A requester may keep `req_valid` high while its own response is pending; it is re-arbitrated in the next IDLE.
- **Reset**
  - Asynchronous return to IDLE. Result register, latched operands and owner go to 0; the round-robin pointer goes to 0.
  - A reset in EXEC or RESP discards the operation and no response is issued.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0x00.
- The accept handshake occurs in cycle T.
  - EXEC is cycle T+1.
  - `resp_valid` is first high in cycle T+2.
- If `resp_ready` is high in T+2, IDLE is in T+3, and the next accept can occur in T+3.
  - Peak throughput is one operation per 3 cycles.
- `resp_data` is stable for the whole time `resp_valid` is high.
- `resp_data` retains the last result after the response is accepted.
- Simultaneous requests are resolved in the same IDLE cycle; there is no bubble.

## Configuration
- `TINY8_ALU_ARB_RR_EN` **defined**: round-robin arbitration.
  - Priority starts at the requester after the last granted one.
  - The pointer updates on each accept to (winner+1) mod NREQ.
- `TINY8_ALU_ARB_RR_EN` **undefined**: fixed priority, lowest index wins.
  - The pointer logic is absent.

## Structure
- `tiny8_types` package holds:
  - `tiny8_word` and `tiny8_aluop` (already present).
  - New `tiny8_arb_state` enum {IDLE, EXEC, RESP}.
  - Constant `TINY8_MAX_REQ`=4.
- Sub-module: one instance of the existing `alu`, fed by the latched op and operands. There is no other sub-module; arbitration is inline.

## Test plan
- **Single request.** Req0 sends add 0x7F+0x01 → `req_ready[0]` in the same cycle, `resp_valid[0]` 2 cycles later with `resp_data`=0x80.
- **Wrap and multiply.** Sub 0x00−0x01 → 0xFF. Mul a=0x13, b=0xF5 → 0x5F (b uses low nibble 5).
- **Contention.** Req0 and req1 both held valid for 4 operations:
  - with the macro defined: grants alternate 0,1,0,1;
  - without the macro: grants are 0,0,0,0 while req0 stays valid.
- **Response backpressure.** `resp_ready[1]` is held low for 5 cycles → `resp_valid[1]` and `resp_data` are held, `req_ready` stays 0, and no new accept occurs until `resp_ready[1]` goes high.
- **Reset mid-operation.** Deassert `rst_n` in EXEC → all outputs are 0 immediately (asynchronously). After release, no stale `resp_valid`, and a new request completes normally.
- **Wrong-owner accept.** `resp_ready[0]` is asserted while req1 owns the response → ignored, and the state stays RESP.
